tcpc_regbus_master: RTL
=======================

# tcpc_regbus_master

Register-bus initiator for the TCPC register block. It accepts register-access commands from the upstream host-interface layer (the I2C slave byte engine). It drives the single-cycle REQUEST/RNW/ADDR/WR_DATA strobe toward the register block and waits for ACK with a timeout. Each access returns a response carrying read data or an error. Read commands may be bursts with address auto-increment, matching TCPCI multi-register reads.

## Interface
- TIMEOUT_CYC, default 8: cycles after the REQUEST cycle to wait for ACK before flagging an error (legal range 2..255).
- MAX_BURST, default 8: maximum read-burst length in beats (legal range 1..15).

- CLK  in  1  single clock; everything is sampled on its rising edge
- RESET  in  1  reset; synchronous, active-high
- CMD_VALID  in  1  command present
- CMD_READY  out  1  master idle and able to accept a command
- CMD_RNW  in  1  1 = read, 0 = write
- CMD_ADDR  in  8  first register address
- CMD_WDATA  in  16  write data; ignored for reads
- CMD_LEN  in  4  read beats; 0 is treated as 1; values above MAX_BURST are clamped to MAX_BURST; ignored for writes
- RSP_VALID  out  1  response present
- RSP_READY  in  1  upstream accepts the response
- RSP_RDATA  out  16  read data; 0 for writes and for errors
- RSP_ERR  out  1  ACK timeout occurred on this beat
- RSP_LAST  out  1  final response of the command
- REQUEST  out  1  register-bus strobe, exactly one cycle wide per beat
- RNW  out  1  register-bus direction
- ADDR  out  8  register-bus address
- WR_DATA  out  16  register-bus write data
- RD_DATA  in  16  register read data; valid in the ACK cycle
- ACK  in  1  register-bus acknowledge, one cycle wide

## Operation
- States are IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - CMD_READY=1.
  - On CMD_VALID: latch RNW, ADDR, WDATA and the effective length (beats_left).
  - Go to ISSUE.
- **ISSUE**
  - REQUEST=1 for exactly this cycle, with RNW, ADDR and WR_DATA stable.
  - Clear the timeout counter.
  - Go to WAIT.
- **WAIT**
  - ACK=1: capture RD_DATA (reads) or 0 (writes); set ERR=0; go to RESP.
  - If the counter reaches TIMEOUT_CYC with no ACK: set RDATA=0, ERR=1 and beats_left=1 so the burst aborts; go to RESP.
- **RESP**
  - RSP_VALID=1 and RSP_LAST=(beats_left==1).
  - Hold RSP_VALID and all RSP_* fields stable until RSP_READY.
  - On handshake with LAST: go to IDLE.
  - On handshake without LAST: ADDR<=ADDR+1 (mod 256, so 0xFF wraps to 0x00), decrement beats_left, go to ISSUE.
- **Ignored ACKs.** ACK in IDLE, ISSUE or RESP is ignored. This includes a late ACK arriving after a timeout, which must not produce a response.
- **Outputs outside ISSUE.** REQUEST is never high outside ISSUE. ADDR, RNW and WR_DATA hold their last values between beats.
- **Writes** are always single-beat; RSP_LAST=1.

## Timing
- **Reset values:** state=IDLE; CMD_READY=1; REQUEST=0; RNW=1; ADDR=0; WR_DATA=0; RSP_VALID=0; RSP_RDATA=0; RSP_ERR=0; RSP_LAST=0; beats_left=0; timeout counter=0.
- **Command accept:** cycle 0 is the CMD_VALID&&CMD_READY handshake. REQUEST is high in cycle 1.
- **Register response:** the register block answers ACK in cycle 2. RSP_VALID rises in cycle 3.
  - Minimum command-to-response latency is 3 cycles.
  - With RSP_READY held high, burst beat period is 3 cycles.
- **Timeout:** with no ACK, RSP_VALID with ERR rises TIMEOUT_CYC+2 cycles after the accept cycle.
- **Command stalls:** CMD_READY=0 from the cycle after accept until the cycle after the final response handshake.
- **RESET asserted mid-transaction:** at the next edge all outputs take their reset values, including REQUEST=0. A pending ACK is then ignored.
- **RSP_READY low:** the response stalls indefinitely; no REQUEST is issued while stalled.

## Structure
- Shared include tcpc_regbus_defs.vh holds:
  - the state encodings (2-bit: IDLE=0, ISSUE=1, WAIT=2, RESP=3);
  - the default TIMEOUT_CYC and MAX_BURST;
  - named TCPCI address constants (e.g. VBUS_VOLTAGE=8'h70, TRANSMIT=8'h50) for use by benches and by the host layer.
- One sub-module, tcpc_regbus_timeout: an 8-bit counter with clear and enable, and a terminal-count output at TIMEOUT_CYC.
- The FSM and datapath stay in the top module.

## Test plan
- **Single read:** read of 0x70 with the register block returning 16'h1234 -> REQUEST pulses once in cycle 1; response RDATA=16'h1234, ERR=0, LAST=1 in cycle 3.
- **Single write:** write of 0x19 with WDATA=16'h00A5 -> one REQUEST with RNW=0, WR_DATA=16'h00A5; response RDATA=0, LAST=1.
- **Read burst across wrap:** CMD_ADDR=0xFE, LEN=3 -> ADDR sequence 0xFE, 0xFF, 0x00; three responses, LAST only on the third; exactly 3 REQUEST pulses.
- **Timeout abort:** LEN=4 burst where the second address is unmapped (no ACK) -> first beat OK; second beat has ERR=1, RDATA=0, LAST=1; no further REQUEST. An ACK injected later is ignored.
- **Backpressure:** RSP_READY held low for 10 cycles in the middle of a burst -> RSP fields stay stable, REQUEST stays 0, and the burst then resumes.
- **Reset mid-transaction:** RESET asserted in the WAIT state -> next cycle REQUEST=0, RSP_VALID=0, CMD_READY=1; the subsequent ACK is ignored and the next command works normally.

Source files
------------

// File: rtl/tcpc_regbus_pkg.sv
// Shared definitions for the TCPC register-bus initiator: FSM encodings, parameter
// defaults, TCPCI register addresses and the burst-length helper.
package tcpc_regbus_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam int DEF_TIMEOUT_CYC = 8;
    localparam int DEF_MAX_BURST   = 8;

    localparam logic [7:0] REG_ALERT        = 8'h10;
    localparam logic [7:0] REG_TCPC_CONTROL = 8'h19;
    localparam logic [7:0] REG_TRANSMIT     = 8'h50;
    localparam logic [7:0] REG_VBUS_VOLTAGE = 8'h70;

    typedef struct packed {
        logic        rnw;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } regbus_req_t;

    // Writes are single-beat; a zero read length means one beat; long reads clamp.
    function automatic logic [3:0] eff_len(input logic rnw, input logic [3:0] len,
                                           input int max_burst);
        logic [3:0] n;
        if (!rnw || len == 4'd0) begin
            n = 4'd1;
        end else if (int'(len) > max_burst) begin
            n = 4'(max_burst);
        end else begin
            n = len;
        end
        return n;
    endfunction

endpackage

// File: rtl/tcpc_regbus_timeout.sv
// ACK timeout counter: cleared when a beat is issued, counts while waiting, and
// flags the cycle in which the count reaches TIMEOUT_CYC.
module tcpc_regbus_timeout #(
    parameter int TIMEOUT_CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT_CYC - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // tc is raised in the waiting cycle whose increment would bring the count to TIMEOUT_CYC.
    assign tc = en && !clr && (cnt_q == TC_VAL);

endmodule

// File: rtl/tcpc_regbus_master.sv
// Register-bus initiator: turns host commands into single-cycle REQUEST strobes,
// waits for ACK with a timeout, and returns one response per beat.
module tcpc_regbus_master
    import tcpc_regbus_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int MAX_BURST   = DEF_MAX_BURST
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_RNW,
    input  logic [7:0]  CMD_ADDR,
    input  logic [15:0] CMD_WDATA,
    input  logic [3:0]  CMD_LEN,
    output logic        RSP_VALID,
    input  logic        RSP_READY,
    output logic [15:0] RSP_RDATA,
    output logic        RSP_ERR,
    output logic        RSP_LAST,
    output logic        REQUEST,
    output logic        RNW,
    output logic [7:0]  ADDR,
    output logic [15:0] WR_DATA,
    input  logic [15:0] RD_DATA,
    input  logic        ACK
);

    logic [1:0]  state_q, state_d;
    regbus_req_t req_q, req_d;
    logic [3:0]  beats_q, beats_d;
    logic [15:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tmo_clr, tmo_en, tmo_tc;

    tcpc_regbus_timeout #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timeout (
        .clk(CLK),
        .rst(RESET),
        .clr(tmo_clr),
        .en (tmo_en),
        .tc (tmo_tc)
    );

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        beats_d = beats_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    req_d.rnw   = CMD_RNW;
                    req_d.addr  = CMD_ADDR;
                    req_d.wdata = CMD_WDATA;
                    beats_d     = eff_len(CMD_RNW, CMD_LEN, MAX_BURST);
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_clr = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_en = 1'b1;
                if (ACK) begin
                    rdata_d = req_q.rnw ? RD_DATA : 16'h0000;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (tmo_tc) begin
                    // Forcing a single remaining beat makes this error response the last one.
                    rdata_d = 16'h0000;
                    err_d   = 1'b1;
                    beats_d = 4'd1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    if (beats_q == 4'd1) begin
                        state_d = ST_IDLE;
                    end else begin
                        req_d.addr = req_q.addr + 8'd1;
                        beats_d    = beats_q - 4'd1;
                        state_d    = ST_ISSUE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            req_q   <= '{rnw: 1'b1, addr: 8'h00, wdata: 16'h0000};
            beats_q <= 4'd0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            beats_q <= beats_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign CMD_READY = (state_q == ST_IDLE);
    assign REQUEST   = (state_q == ST_ISSUE);
    assign RNW       = req_q.rnw;
    assign ADDR      = req_q.addr;
    assign WR_DATA   = req_q.wdata;
    assign RSP_VALID = (state_q == ST_RESP);
    assign RSP_LAST  = RSP_VALID && (beats_q == 4'd1);
    assign RSP_RDATA = rdata_q;
    assign RSP_ERR   = err_q;

endmodule
